// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 decoding types and constants for the keycode path.
package ps2_pkg;

  typedef enum logic [1:0] {
    F_IDLE,
    F_DATA,
    F_PARITY,
    F_STOP
  } frame_state_t;

  typedef enum logic [1:0] {
    P_BASE,
    P_EXT,
    P_BRK,
    P_EXTBRK
  } prefix_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_SPACE = 8'h29;

  // A frame is good when data plus parity hold an odd number of ones and stop is high.
  function automatic logic frame_ok(input logic [7:0] d, input logic par, input logic stop);
    return (^{d, par}) & stop;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: pin synchroniser, falling-edge detect, frame FSM and
// mid-frame timeout. Emits one-cycle byte_rdy with data, or err.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_rdy,
  output logic [7:0] data,
  output logic       err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   din;

  frame_state_t           state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   parity;
  logic [CNT_W-1:0]       cnt;

  // Synchronisers reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign din  = data_sync[SYNC_STAGES-1];

  // Frame FSM; a falling edge always wins over a coincident timeout.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= F_IDLE;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      parity   <= 1'b0;
      cnt      <= '0;
      byte_rdy <= 1'b0;
      data     <= 8'h00;
      err      <= 1'b0;
    end else begin
      byte_rdy <= 1'b0;
      err      <= 1'b0;
      if (fall) begin
        cnt <= '0;
        unique case (state)
          F_IDLE: begin
            if (!din) begin
              state   <= F_DATA;
              bit_cnt <= 3'd0;
            end
          end
          F_DATA: begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= F_PARITY;
            end
          end
          F_PARITY: begin
            parity <= din;
            state  <= F_STOP;
          end
          F_STOP: begin
            if (frame_ok(shreg, parity, din)) begin
              byte_rdy <= 1'b1;
              data     <= shreg;
            end else begin
              err <= 1'b1;
            end
            state <= F_IDLE;
          end
        endcase
      end else if (state != F_IDLE) begin
        if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err   <= 1'b1;
          state <= F_IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/keycode_decoder.sv
// PS/2 Set-2 keyboard decoder: tracks make/break/extended prefixes and holds
// the make code of the currently pressed key for the game-control logic.
module keycode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       extended,
  output logic       key_strobe,
  output logic       frame_err
);

  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          rx_err;

  prefix_state_t pstate;
  logic          byte_ext_c;
  logic          held_match_c;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .Clk     (Clk),
    .Reset   (Reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .byte_rdy(rx_rdy),
    .data    (rx_data),
    .err     (rx_err)
  );

  // rx_err is already a registered one-cycle pulse.
  assign frame_err = rx_err;

  always_comb begin
    byte_ext_c   = 1'b0;
    held_match_c = 1'b0;
    byte_ext_c   = (pstate == P_EXT) || (pstate == P_EXTBRK);
    held_match_c = ({byte_ext_c, rx_data} == {extended, keycode});
  end

  // Prefix FSM and held-key registers; an error only resets the prefix.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pstate     <= P_BASE;
      keycode    <= 8'h00;
      extended   <= 1'b0;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (rx_err) begin
        pstate <= P_BASE;
      end else if (rx_rdy) begin
        unique case (pstate)
          P_BASE, P_EXT: begin
            if (rx_data == PS2_BREAK) begin
              pstate <= (pstate == P_EXT) ? P_EXTBRK : P_BRK;
            end else if (rx_data == PS2_EXT) begin
              pstate <= P_EXT;
            end else begin
              pstate <= P_BASE;
              // Typematic repeats of the held key and null makes leave outputs alone.
              if ((rx_data != 8'h00) && !held_match_c) begin
                keycode    <= rx_data;
                extended   <= byte_ext_c;
                key_strobe <= 1'b1;
              end
            end
          end
          P_BRK, P_EXTBRK: begin
            pstate <= P_BASE;
            if (held_match_c) begin
              keycode  <= 8'h00;
              extended <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/keycode_decoder.md
Name: keycode_decoder

Overview:
- Source end of the `keycode` bus consumed by the ball/cursor logic.
- Receives PS/2 keyboard frames on the raw PS/2 pins and decodes Set-2 make, break (F0) and extended (E0) sequences.
- Presents a registered 8-bit `keycode` for the key currently held, plus strobes for new presses and frame errors.
- Sits between the board PS/2 pins and the game-control logic, all on the system clock.

Parameters:
- TIMEOUT_CYCLES, 100000, Clk cycles without a PS/2 falling edge mid-frame before the partial frame is aborted (2 ms at 50 MHz).
- SYNC_STAGES, 2, flop stages synchronising ps2_clk and ps2_data into Clk.

Ports:
- Clk  input  1  system clock, 50 MHz.
- Reset  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous to Clk.
- ps2_data  input  1  raw PS/2 data pin, asynchronous to Clk.
- keycode  output  8  make code of the currently held key; 8'h00 when none is held.
- extended  output  1  held key was prefixed by E0; valid while keycode != 0.
- key_strobe  output  1  one-cycle pulse when keycode takes a new non-zero value.
- frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error.

Behaviour:
- Clock and reset: one clock domain (Clk); Reset is asynchronous and active-high. All state and outputs clear on Reset: keycode=0, extended=0, key_strobe=0, frame_err=0. Frame FSM goes to F_IDLE, prefix FSM to P_BASE, timeout counter to 0.
- Input conditioning: ps2_clk and ps2_data each pass through SYNC_STAGES flops. A falling edge of synced ps2_clk (prev=1, cur=0) produces `fall` for one cycle, and ps2_data is sampled on that cycle.
- Frame FSM:
  - F_IDLE: on `fall` with data=0 (start bit), go to F_DATA with bit_cnt=0. On `fall` with data=1, stay in F_IDLE with no error.
  - F_DATA: shift the 8 data bits in LSB first; after bit 7 go to F_PARITY.
  - F_PARITY: capture the parity bit, then go to F_STOP.
  - F_STOP: capture the stop bit. If the 8 data bits plus parity have an odd count of ones and stop=1, emit `byte_rdy` with the byte for one cycle; otherwise pulse frame_err. Return to F_IDLE in both cases.
- Timeout: the counter counts up while the frame FSM is not in F_IDLE and clears on every `fall`. When it reaches TIMEOUT_CYCLES-1: pulse frame_err, go to F_IDLE, discard partial data.
- Prefix FSM (advances only on `byte_rdy`):
  - P_BASE: F0 goes to P_BRK; E0 goes to P_EXT; any other byte is a make code.
  - P_EXT: F0 goes to P_EXTBRK; E0 stays in P_EXT; any other byte is an extended make. Return to P_BASE.
  - P_BRK / P_EXTBRK: the byte is a break code (extended for P_EXTBRK). Return to P_BASE.
- Make handling:
  - If {ext, byte} equals the held {extended, keycode}, it is typematic repeat: no output change, no strobe.
  - Otherwise load keycode=byte and extended=ext, and pulse key_strobe.
  - A make of 8'h00 is ignored.
- Break handling: if {ext, byte} matches the held key, set keycode=0 and extended=0 with no strobe. A break for a non-held key is ignored.
- Error recovery: a frame_err, from any cause, also forces the prefix FSM to P_BASE. Held keycode is unchanged.
- Latency: keycode, extended and key_strobe update on the Clk edge after `byte_rdy`. `byte_rdy` is the cycle after `fall` for the stop bit. The pin-to-output bound is SYNC_STAGES+2 Clk cycles after the stop-bit falling edge on ps2_clk.
- Simultaneous events: a timeout and a `fall` in the same cycle resolve with `fall` winning (counter clears, no error). The output registers see at most one byte_rdy per cycle by construction.
- Reset mid-frame: everything aborts immediately. The next valid start bit begins a fresh frame, and no error is reported for the aborted frame.

Decomposition:
- Shared package `ps2_pkg`:
  - Frame FSM enum: F_IDLE, F_DATA, F_PARITY, F_STOP.
  - Prefix FSM enum: P_BASE, P_EXT, P_BRK, P_EXTBRK.
  - Constants: PS2_BREAK=8'hF0, PS2_EXT=8'hE0, and game keys KEY_A=8'h1C, KEY_D=8'h23, KEY_SPACE=8'h29.
- Sub-module `ps2_rx`: synchroniser, edge detect, frame FSM and timeout; outputs byte_rdy, byte[7:0] and err. The top level holds the prefix FSM and the output registers.

Test Plan:
- Reset, then frame 8'h1C with correct parity (odd) and stop=1 -> key_strobe for 1 cycle, keycode=8'h1C, extended=0 within 4 Clk of the stop edge.
- Typematic repeat: 1C, 1C, 1C, then F0 1C -> key_strobe only on the first 1C; keycode returns to 8'h00 after the break, with no strobe.
- Extended key: E0 74, then E0 F0 74 -> keycode=8'h74, extended=1 with one strobe; both return to 0 after the release.
- Parity error: send 8'h23 with the parity bit inverted -> frame_err pulse, keycode unchanged. A following correct 8'h23 -> keycode=8'h23 with strobe.
- Timeout: send start plus 4 data bits, then idle for TIMEOUT_CYCLES -> exactly one frame_err. A following full 8'h29 frame decodes correctly. Also check a pending F0 is cleared by the error: F0, bad frame, 29 is treated as a make.
- Async reset: assert Reset mid-frame while keycode=8'h1C -> all outputs are 0 immediately, without waiting for a Clk edge. After release, the next 8'h1C frame yields a strobe.
